// File: rtl/pipe_stage_skid.sv
// Pipeline register stage with optional two-entry skid buffer.
// SKID=1: main entry M plus skid entry S, in_ready driven straight from a flop
//         so out_ready never reaches in_ready combinationally.
// SKID=0: single entry M, in_ready = ~M.valid | out_ready.
// Flush clears the valid bits only; stored ctrl/data bits are left untouched.
module pipe_stage_skid #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 9,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    localparam logic HAS_SKID = (SKID != 32'sd0);

    // Main entry (drives the outputs)
    logic              m_valid_r;
    logic [CTRL_W-1:0] m_ctrl_r;
    logic [DATA_W-1:0] m_data_r;
    // Skid entry (only ever filled when HAS_SKID)
    logic              s_valid_r;
    logic [CTRL_W-1:0] s_ctrl_r;
    logic [DATA_W-1:0] s_data_r;
    // Registered copies of derived outputs
    logic              ready_r;
    logic [CTRL_W-1:0] out_ctrl_r;
    logic [1:0]        count_r;

    // Next-state values
    logic              m_valid_s;
    logic [CTRL_W-1:0] m_ctrl_s;
    logic [DATA_W-1:0] m_data_s;
    logic              s_valid_s;
    logic [CTRL_W-1:0] s_ctrl_s;
    logic [DATA_W-1:0] s_data_s;
    logic              ready_s;
    logic [CTRL_W-1:0] out_ctrl_s;
    logic [1:0]        count_s;

    // Handshake terms
    logic ix_s;
    logic ox_s;
    logic m_take_s;

    // Upstream ready: flop output with a skid entry, pass-through otherwise
    always_comb begin
        if (HAS_SKID) begin
            in_ready = ready_r;
        end else begin
            in_ready = ~m_valid_r | out_ready;
        end
    end

    // Transfer qualifiers for both sides of the stage
    always_comb begin
        ix_s     = in_valid & in_ready;
        ox_s     = m_valid_r & out_ready;
        m_take_s = ~m_valid_r | ox_s;
    end

    // Next-state computation for M, S and the registered outputs
    always_comb begin
        m_valid_s = m_valid_r;
        m_ctrl_s  = m_ctrl_r;
        m_data_s  = m_data_r;
        s_valid_s = s_valid_r;
        s_ctrl_s  = s_ctrl_r;
        s_data_s  = s_data_r;

        if (m_take_s) begin
            if (s_valid_r) begin
                // Oldest held entry moves forward; S is never written in the
                // same cycle because in_ready is low while S is occupied.
                m_valid_s = 1'b1;
                m_ctrl_s  = s_ctrl_r;
                m_data_s  = s_data_r;
                s_valid_s = 1'b0;
            end else if (ix_s) begin
                m_valid_s = 1'b1;
                m_ctrl_s  = in_ctrl;
                m_data_s  = in_data;
            end else begin
                m_valid_s = 1'b0;
            end
        end else begin
            // M is stalled: a newly accepted entry parks in S
            if (ix_s && HAS_SKID) begin
                s_valid_s = 1'b1;
                s_ctrl_s  = in_ctrl;
                s_data_s  = in_data;
            end else begin
                s_valid_s = s_valid_r;
            end
        end

        // Flush drops every held entry (including one accepted this cycle)
        // but keeps the payload bits as they are.
        if (flush) begin
            m_valid_s = 1'b0;
            s_valid_s = 1'b0;
        end else begin
            m_valid_s = m_valid_s;
        end

        ready_s    = ~s_valid_s;
        out_ctrl_s = m_valid_s ? m_ctrl_s : {CTRL_W{1'b0}};
        count_s    = {1'b0, m_valid_s} + {1'b0, s_valid_s};
    end

    // State registers with synchronous reset taking priority over flush
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid_r  <= 1'b0;
            m_ctrl_r   <= {CTRL_W{1'b0}};
            m_data_r   <= {DATA_W{1'b0}};
            s_valid_r  <= 1'b0;
            s_ctrl_r   <= {CTRL_W{1'b0}};
            s_data_r   <= {DATA_W{1'b0}};
            ready_r    <= 1'b1;
            out_ctrl_r <= {CTRL_W{1'b0}};
            count_r    <= 2'd0;
        end else begin
            m_valid_r  <= m_valid_s;
            m_ctrl_r   <= m_ctrl_s;
            m_data_r   <= m_data_s;
            s_valid_r  <= s_valid_s;
            s_ctrl_r   <= s_ctrl_s;
            s_data_r   <= s_data_s;
            ready_r    <= ready_s;
            out_ctrl_r <= out_ctrl_s;
            count_r    <= count_s;
        end
    end

    assign out_valid = m_valid_r;
    assign out_data  = m_data_r;
    assign out_ctrl  = out_ctrl_r;
    assign count     = count_r;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed + scoreboarded bench for pipe_stage_skid, SKID=1 (a_*) and SKID=0 (b_*).
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [8:0]  a_in_ctrl, a_out_ctrl;
    logic [63:0] a_in_data, a_out_data;
    logic [1:0]  a_count;

    logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [8:0]  b_in_ctrl, b_out_ctrl;
    logic [63:0] b_in_data, b_out_data;
    logic [1:0]  b_count;

    pipe_stage_skid #(.DATA_W(64), .CTRL_W(9), .SKID(1)) dut_a (
        .clk(clk), .rst(a_rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .count(a_count)
    );

    pipe_stage_skid #(.DATA_W(64), .CTRL_W(9), .SKID(0)) dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .count(b_count)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [8:0]  ctrl;
        logic [63:0] data;
    } entry_t;

    entry_t qa[$];
    entry_t qb[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_a(input logic [8:0] c, input logic [63:0] d);
        a_in_valid = 1'b1;
        a_in_ctrl  = c;
        a_in_data  = d;
    endtask

    initial begin
        a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        a_in_ctrl = 9'h000; a_in_data = 64'h0;
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0;
        b_in_ctrl = 9'h000; b_in_data = 64'h0;
        tick();
        tick();
        a_rst = 1'b0; b_rst = 1'b0;
        #1;

        // Reset state
        check("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
        check("rst_out_ctrl",  {55'd0, a_out_ctrl},  64'd0);
        check("rst_out_data",  a_out_data,           64'd0);
        check("rst_count",     {62'd0, a_count},     64'd0);
        check("rst_in_ready",  {63'd0, a_in_ready},  64'd1);
        check("rst_b_in_ready", {63'd0, b_in_ready}, 64'd1);

        // One-cycle latency
        a_out_ready = 1'b1;
        offer_a(9'h1A5, 64'hDEAD);
        tick();
        a_in_valid = 1'b0;
        check("lat_out_valid", {63'd0, a_out_valid}, 64'd1);
        check("lat_out_ctrl",  {55'd0, a_out_ctrl},  64'h1A5);
        check("lat_out_data",  a_out_data,           64'hDEAD);
        check("lat_count",     {62'd0, a_count},     64'd1);
        tick();
        check("lat_drain_valid", {63'd0, a_out_valid}, 64'd0);
        check("lat_drain_ctrl",  {55'd0, a_out_ctrl},  64'd0);
        check("lat_drain_count", {62'd0, a_count},     64'd0);

        // Stall: A, B accepted, C refused, then A, B, C in order
        a_out_ready = 1'b0;
        offer_a(9'h00A, 64'hAAAA);
        tick();
        check("stall_rdy_after_a", {63'd0, a_in_ready}, 64'd1);
        offer_a(9'h00B, 64'hBBBB);
        tick();
        check("stall_count2", {62'd0, a_count}, 64'd2);
        check("stall_hold_a", a_out_data, 64'hAAAA);
        offer_a(9'h00C, 64'hCCCC);
        #1;
        check("stall_c_refused", {63'd0, a_in_ready}, 64'd0);
        tick();
        check("stall_count_still2", {62'd0, a_count}, 64'd2);
        check("stall_a_stable", a_out_data, 64'hAAAA);
        a_out_ready = 1'b1;
        #1;
        check("order_a_data", a_out_data, 64'hAAAA);
        check("order_a_ctrl", {55'd0, a_out_ctrl}, 64'h00A);
        tick();
        check("order_b_data", a_out_data, 64'hBBBB);
        check("order_b_ctrl", {55'd0, a_out_ctrl}, 64'h00B);
        check("order_b_rdy", {63'd0, a_in_ready}, 64'd1);
        tick();
        a_in_valid = 1'b0;
        check("order_c_data", a_out_data, 64'hCCCC);
        check("order_c_count", {62'd0, a_count}, 64'd1);
        tick();
        check("order_empty", {63'd0, a_out_valid}, 64'd0);

        // Full-throughput stream of 100 entries
        a_out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            offer_a(9'(i), 64'h5000 + 64'(i));
            tick();
            check("stream_data",  a_out_data,          64'h5000 + 64'(i));
            check("stream_count", {62'd0, a_count},    64'd1);
            check("stream_rdy",   {63'd0, a_in_ready}, 64'd1);
        end
        a_in_valid = 1'b0;
        tick();
        check("stream_end", {62'd0, a_count}, 64'd0);

        // Flush with two held entries and an entry on offer
        a_out_ready = 1'b0;
        offer_a(9'h0D1, 64'hD1D1);
        tick();
        offer_a(9'h0D2, 64'hD2D2);
        tick();
        check("fl_pre_count", {62'd0, a_count}, 64'd2);
        offer_a(9'h0D3, 64'hD3D3);
        a_flush = 1'b1;
        #1;
        check("fl_rdy_preflush", {63'd0, a_in_ready}, 64'd0);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("fl_count",     {62'd0, a_count},     64'd0);
        check("fl_out_valid", {63'd0, a_out_valid}, 64'd0);
        check("fl_out_ctrl",  {55'd0, a_out_ctrl},  64'd0);
        check("fl_data_kept", a_out_data,           64'hD1D1);
        check("fl_in_ready",  {63'd0, a_in_ready},  64'd1);
        tick();
        check("fl_offer_absent", {63'd0, a_out_valid}, 64'd0);

        // Flush discards an entry accepted in the flush cycle
        offer_a(9'h0E1, 64'hE1E1);
        tick();
        offer_a(9'h0E2, 64'hE2E2);
        a_flush = 1'b1;
        #1;
        check("fl1_rdy_preflush", {63'd0, a_in_ready}, 64'd1);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        check("fl1_count", {62'd0, a_count}, 64'd0);
        check("fl1_data_kept", a_out_data, 64'hE1E1);
        tick();
        check("fl1_still_empty", {62'd0, a_count}, 64'd0);

        // Reset with two held entries
        offer_a(9'h0F1, 64'hF1F1);
        tick();
        offer_a(9'h0F2, 64'hF2F2);
        tick();
        check("rs_pre_count", {62'd0, a_count}, 64'd2);
        a_rst = 1'b1; a_out_ready = 1'b1; offer_a(9'h0F3, 64'hF3F3);
        tick();
        a_rst = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
        check("rs_count",     {62'd0, a_count},     64'd0);
        check("rs_out_data",  a_out_data,           64'd0);
        check("rs_out_ctrl",  {55'd0, a_out_ctrl},  64'd0);
        check("rs_out_valid", {63'd0, a_out_valid}, 64'd0);
        check("rs_in_ready",  {63'd0, a_in_ready},  64'd1);

        // SKID=0 directed: combinational ready and replace-on-transfer
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_ctrl = 9'h011; b_in_data = 64'h1111;
        tick();
        b_in_valid = 1'b0;
        check("b_fill_valid", {63'd0, b_out_valid}, 64'd1);
        check("b_fill_data",  b_out_data,           64'h1111);
        check("b_fill_count", {62'd0, b_count},     64'd1);
        #1;
        check("b_stall_rdy", {63'd0, b_in_ready}, 64'd0);
        b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_ctrl = 9'h022; b_in_data = 64'h2222;
        #1;
        check("b_same_cycle_rdy", {63'd0, b_in_ready}, 64'd1);
        tick();
        b_in_valid = 1'b0;
        check("b_replace_data",  b_out_data,          64'h2222);
        check("b_replace_ctrl",  {55'd0, b_out_ctrl}, 64'h022);
        check("b_replace_count", {62'd0, b_count},    64'd1);
        tick();
        check("b_drain_count", {62'd0, b_count}, 64'd0);

        // Random traffic on both variants against a FIFO scoreboard
        for (int i = 0; i < 10010; i++) begin
            logic a_exp_rdy, b_exp_rdy, a_ix, b_ix;
            entry_t ea, eb;
            if (i < 10000) begin
                a_in_valid  = ($urandom_range(0, 9) < 7);
                a_out_ready = ($urandom_range(0, 1) == 1);
                b_in_valid  = ($urandom_range(0, 9) < 7);
                b_out_ready = ($urandom_range(0, 1) == 1);
            end else begin
                a_in_valid = 1'b0; a_out_ready = 1'b1;
                b_in_valid = 1'b0; b_out_ready = 1'b1;
            end
            a_in_ctrl = 9'($urandom);  a_in_data = {$urandom, $urandom};
            b_in_ctrl = 9'($urandom);  b_in_data = {$urandom, $urandom};
            #1;
            a_exp_rdy = (qa.size() < 2);
            b_exp_rdy = (qb.size() == 0) || b_out_ready;
            check("rnd_a_rdy",   {63'd0, a_in_ready},  {63'd0, a_exp_rdy});
            check("rnd_a_count", {62'd0, a_count},     64'(qa.size()));
            check("rnd_b_rdy",   {63'd0, b_in_ready},  {63'd0, b_exp_rdy});
            check("rnd_b_count", {62'd0, b_count},     64'(qb.size()));
            a_ix = a_in_valid && a_exp_rdy;
            b_ix = b_in_valid && b_exp_rdy;
            if (qa.size() > 0 && a_out_ready) begin
                ea = qa.pop_front();
                check("rnd_a_data", a_out_data, ea.data);
                check("rnd_a_ctrl", {55'd0, a_out_ctrl}, {55'd0, ea.ctrl});
            end
            if (qb.size() > 0 && b_out_ready) begin
                eb = qb.pop_front();
                check("rnd_b_data", b_out_data, eb.data);
                check("rnd_b_ctrl", {55'd0, b_out_ctrl}, {55'd0, eb.ctrl});
            end
            if (a_ix) qa.push_back({a_in_ctrl, a_in_data});
            if (b_ix) qb.push_back({b_in_ctrl, b_in_data});
            tick();
        end
        check("rnd_a_final_count", {62'd0, a_count}, 64'd0);
        check("rnd_b_final_count", {62'd0, b_count}, 64'd0);
        check("rnd_a_final_valid", {63'd0, a_out_valid}, 64'd0);
        check("rnd_b_final_valid", {63'd0, b_out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
